// File: rtl/atlas_audio_pkg.sv
// Shared audio-path definitions: default frame geometry and the consumer
// handshake states used by the frame controller.
package atlas_audio_pkg;

    localparam int unsigned FRAME_LEN_DEFAULT = 32;
    localparam int unsigned SAMPLE_W_DEFAULT  = 24;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } consumer_state_e;

endpackage

// File: rtl/stereo_mixer.sv
// Combinational stereo-to-mono mix. The channels are summed at W+1 bits, so the
// sum cannot overflow. Halving by dropping the LSB rounds toward minus infinity.
module stereo_mixer #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] left_i,
    input  logic [W-1:0] right_i,
    output logic [W-1:0] mono_o
);

    logic [W:0] sum;

    assign sum    = {left_i[W-1], left_i} + {right_i[W-1], right_i};
    assign mono_o = sum[W:1];

endmodule

// File: rtl/sample_frame_ctrl.sv
// Ping-pong frame capture: it writes mono samples into a two-bank buffer and
// hands each full bank to an FFT consumer, flagging frames dropped while busy.
module sample_frame_ctrl
    import atlas_audio_pkg::*;
#(
    parameter int unsigned N = FRAME_LEN_DEFAULT,
    parameter int unsigned W = SAMPLE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sample_valid,
    input  logic [W-1:0]          left,
    input  logic [W-1:0]          right,
    input  logic                  fft_done,
    input  logic                  clr_overrun,
    output logic                  wr_en,
    output logic [$clog2(N):0]    wr_addr,
    output logic [W-1:0]          wr_data,
    output logic                  fft_start,
    output logic                  fft_bank,
    output logic                  busy,
    output logic                  overrun,
    output logic [15:0]           frame_count
);

    localparam int unsigned   AW       = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    consumer_state_e state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            fill_bank_q, fill_bank_d;
    logic            wr_en_q, wr_en_d;
    logic [AW:0]     wr_addr_q, wr_addr_d;
    logic [W-1:0]    wr_data_q, wr_data_d;
    logic            fft_start_q, fft_start_d;
    logic            fft_bank_q, fft_bank_d;
    logic            overrun_q, overrun_d;
    logic [15:0]     frame_count_q, frame_count_d;

    logic [W-1:0]    mix;
    logic            accept;
    logic            frame_done;
    logic            handoff;

    stereo_mixer #(.W(W)) u_mixer (
        .left_i  (left),
        .right_i (right),
        .mono_o  (mix)
    );

    assign accept     = en && sample_valid;
    assign frame_done = accept && (idx_q == LAST_IDX);
    // A finished bank is handed over only if the consumer is free, or frees up on this same edge.
    assign handoff    = frame_done && ((state_q == IDLE) || fft_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            fill_bank_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            fft_start_q   <= 1'b0;
            fft_bank_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fill_bank_q   <= fill_bank_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            fft_start_q   <= fft_start_d;
            fft_bank_q    <= fft_bank_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fill_bank_d   = fill_bank_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        fft_start_d   = 1'b0;
        fft_bank_d    = fft_bank_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;

        if (!en) begin
            idx_d = '0;
        end else if (sample_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {fill_bank_q, idx_q};
            wr_data_d = mix;
            idx_d     = idx_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (handoff) state_d = BUSY;
            end
            BUSY: begin
                if (!handoff && fft_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (handoff) begin
            fft_start_d   = 1'b1;
            fft_bank_d    = fill_bank_q;
            fill_bank_d   = ~fill_bank_q;
            frame_count_d = frame_count_q + 16'd1;
        end

        // Setting wins over clearing when both land on the same edge.
        if (clr_overrun) overrun_d = 1'b0;
        if (frame_done && !handoff) overrun_d = 1'b1;
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign fft_start   = fft_start_q;
    assign fft_bank    = fft_bank_q;
    assign busy        = (state_q == BUSY);
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Scoreboard bench for sample_frame_ctrl (N=32, W=24): the stimulus side queues
// the expected writes and handoffs, and a negedge monitor pops and compares them.
module tb_sample_frame_ctrl;

    localparam int N = 32;
    localparam int W = 24;

    typedef struct packed {
        logic [5:0]  addr;
        logic [23:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic        bank;
        logic [15:0] count;
    } ho_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          sample_valid;
    logic [W-1:0]  left;
    logic [W-1:0]  right;
    logic          fft_done;
    logic          clr_overrun;
    logic          wr_en;
    logic [5:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          fft_start;
    logic          fft_bank;
    logic          busy;
    logic          overrun;
    logic [15:0]   frame_count;

    wr_exp_t wrQueue[$];
    ho_exp_t hoQueue[$];
    int      testsRun    = 0;
    int      testsFailed = 0;

    sample_frame_ctrl #(.N(N), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .sample_valid (sample_valid),
        .left         (left),
        .right        (right),
        .fft_done     (fft_done),
        .clr_overrun  (clr_overrun),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .fft_start    (fft_start),
        .fft_bank     (fft_bank),
        .busy         (busy),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; returns just after the edge that consumed them.
    task automatic applyStimulus(input logic sv, input logic [W-1:0] l, input logic [W-1:0] r,
                                 input logic done, input logic clr);
        sample_valid = sv;
        left         = l;
        right        = r;
        fft_done     = done;
        clr_overrun  = clr;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        clr_overrun  = 1'b0;
    endtask

    task automatic writeSample(input logic [W-1:0] l, input logic [W-1:0] r,
                               input logic [5:0] addr, input logic [W-1:0] data, input logic done);
        wr_exp_t e;
        e.addr = addr;
        e.data = data;
        wrQueue.push_back(e);
        applyStimulus(1'b1, l, r, done, 1'b0);
    endtask

    task automatic expectHandoff(input logic bank, input logic [15:0] count);
        ho_exp_t h;
        h.bank  = bank;
        h.count = count;
        hoQueue.push_back(h);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " wr_en"},       32'(wr_en),       32'd0);
        checkOutput({tag, " wr_addr"},     32'(wr_addr),     32'd0);
        checkOutput({tag, " wr_data"},     32'(wr_data),     32'd0);
        checkOutput({tag, " fft_start"},   32'(fft_start),   32'd0);
        checkOutput({tag, " fft_bank"},    32'(fft_bank),    32'd0);
        checkOutput({tag, " busy"},        32'(busy),        32'd0);
        checkOutput({tag, " overrun"},     32'(overrun),     32'd0);
        checkOutput({tag, " frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // The monitor samples on the falling edge, away from the registering edge.
    initial begin
        wr_exp_t e;
        ho_exp_t h;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                if (wrQueue.size() == 0) begin
                    checkOutput("unexpected wr_en", 32'(wr_en), 32'd0);
                end else begin
                    e = wrQueue.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
                    checkOutput("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (fft_start === 1'b1) begin
                if (hoQueue.size() == 0) begin
                    checkOutput("unexpected fft_start", 32'(fft_start), 32'd0);
                end else begin
                    h = hoQueue.pop_front();
                    checkOutput("fft_bank at start",    32'(fft_bank),    32'(h.bank));
                    checkOutput("frame_count at start", 32'(frame_count), 32'(h.count));
                end
            end
        end
    end

    initial begin
        reset        = 1'b0;
        en           = 1'b0;
        sample_valid = 1'b0;
        left         = '0;
        right        = '0;
        fft_done     = 1'b0;
        clr_overrun  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b1;
        en    = 1'b1;

        // Frame 0 into bank 0, opening with the mixer corner cases.
        writeSample(24'h7FFFFF, 24'h7FFFFF, 6'd0, 24'h7FFFFF, 1'b0);
        writeSample(24'h800000, 24'h800000, 6'd1, 24'h800000, 1'b0);
        writeSample(24'h000001, 24'hFFFFFE, 6'd2, 24'hFFFFFF, 1'b0);
        writeSample(24'hFFFFFD, 24'h000000, 6'd3, 24'hFFFFFE, 1'b0);
        for (int i = 4; i < 31; i++)
            writeSample(24'(i * 16), 24'(i * 4), 6'(i), 24'(i * 10), 1'b0);
        expectHandoff(1'b0, 16'd1);
        writeSample(24'(31 * 16), 24'(31 * 4), 6'd31, 24'd310, 1'b0);
        checkOutput("busy after frame 0",        32'(busy),        32'd1);
        checkOutput("fft_bank after frame 0",    32'(fft_bank),    32'd0);
        checkOutput("frame_count after frame 0", 32'(frame_count), 32'd1);
        idle(1);
        checkOutput("fft_start single cycle", 32'(fft_start), 32'd0);

        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("busy released", 32'(busy), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("fft_done in idle ignored", 32'(busy), 32'd0);

        // Bank 1 fills and hands off; bank 0 then completes while busy.
        for (int i = 0; i < 31; i++)
            writeSample(24'(i), 24'(i), 6'(32 + i), 24'(i), 1'b0);
        expectHandoff(1'b1, 16'd2);
        writeSample(24'd31, 24'd31, 6'd63, 24'd31, 1'b0);
        checkOutput("fft_bank after frame 1",    32'(fft_bank),    32'd1);
        checkOutput("frame_count after frame 1", 32'(frame_count), 32'd2);
        for (int i = 0; i < 32; i++)
            writeSample(24'(200 + i), 24'(100 + i), 6'(i), 24'(150 + i), 1'b0);
        checkOutput("overrun set",             32'(overrun),     32'd1);
        checkOutput("no fft_start on overrun", 32'(fft_start),   32'd0);
        checkOutput("frame_count on overrun",  32'(frame_count), 32'd2);
        checkOutput("fft_bank held on overrun",32'(fft_bank),    32'd1);
        checkOutput("busy held on overrun",    32'(busy),        32'd1);
        writeSample(24'd5, 24'd5, 6'd0, 24'd5, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("overrun cleared", 32'(overrun), 32'd0);

        // Completion coincident with fft_done hands off directly.
        for (int i = 1; i < 31; i++)
            writeSample(24'd7, 24'd9, 6'(i), 24'd8, 1'b0);
        expectHandoff(1'b0, 16'd3);
        writeSample(24'd7, 24'd9, 6'd31, 24'd8, 1'b1);
        checkOutput("busy after coincident done", 32'(busy),        32'd1);
        checkOutput("frame_count coincident",     32'(frame_count), 32'd3);
        checkOutput("overrun stays clear",        32'(overrun),     32'd0);

        // Partial frame in bank 1, then a one-cycle reset.
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            writeSample(24'd2, 24'd2, 6'(32 + i), 24'd2, 1'b0);
        idle(1);
        reset = 1'b0;
        #1;
        checkAllZero("mid-frame reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        writeSample(24'd3, 24'd3, 6'd0, 24'd3, 1'b0);

        // Disable after 10 samples restarts the index.
        for (int i = 1; i < 10; i++)
            writeSample(24'd4, 24'd4, 6'(i), 24'd4, 1'b0);
        en = 1'b0;
        applyStimulus(1'b1, 24'h10, 24'h10, 1'b0, 1'b0);
        en = 1'b1;
        writeSample(24'd6, 24'd6, 6'd0, 24'd6, 1'b0);
        idle(2);

        checkOutput("write queue drained",   32'(wrQueue.size()), 32'd0);
        checkOutput("handoff queue drained", 32'(hoQueue.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
